// File: rtl/apb2_master_bridge_if.sv
// Request/response stream plus APB2 bus bundle for apb2_master_bridge.
// Latency: none, wiring only.
// Backpressure: req_ready/rsp_ready carry the stream handshakes; APB2 has no wait states.
interface apb2_master_bridge_if #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 8,
    parameter int LEN_BITS  = 4
);
    // host request stream
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic [LEN_BITS-1:0]  req_len;

    // read response stream
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 rsp_last;

    // APB2 bus
    logic [ADDR_BITS-1:0] PADDR;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [DATA_BITS-1:0] PWDATA;
    logic [DATA_BITS-1:0] PRDATA;

    // bridge view
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, PRDATA,
        output req_ready, rsp_valid, rsp_data, rsp_last,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    // environment view: request source, response sink and APB2 slave
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, PRDATA,
        input  req_ready, rsp_valid, rsp_data, rsp_last,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb2_master_bridge.sv
// Command stream to APB2 master; bursts auto-increment PADDR (enabled by APB2_MASTER_BURST_EN).
// Latency: write beat = SETUP+ACCESS (2 cycles); read beat = SETUP+ACCESS+RESP (>=3 cycles).
// Backpressure: req_ready only in IDLE; bus parks (PSEL=0) in RESP until rsp_ready.
module apb2_master_bridge #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 8,
    parameter int LEN_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    apb2_master_bridge_if.master   bus,
    output logic                   busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 write_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 accept;
    logic                 last_beat;
    logic                 next_beat;

    assign accept = bus.req_valid && bus.req_ready;

    // Moving on to another beat happens either straight out of a write
    // ACCESS or when a read response is taken.
    assign next_beat = !last_beat &&
                       (((state_q == ACCESS) && write_q) ||
                        ((state_q == RESP) && bus.rsp_ready));

`ifdef APB2_MASTER_BURST_EN
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] beat_q;

    // Equality compare at LEN_BITS width: len of all-ones gives 2^LEN_BITS beats.
    assign last_beat = (beat_q == len_q);

    // Beat counter and burst length, loaded on request acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            beat_q <= '0;
        end else if (accept) begin
            len_q  <= bus.req_len;
            beat_q <= '0;
        end else if (next_beat) begin
            beat_q <= beat_q + LEN_BITS'(1);
        end
    end

    // Address register: start address on accept, +1 per beat, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= bus.req_addr;
        end else if (next_beat) begin
            addr_q <= addr_q + ADDR_BITS'(1);
        end
    end
`else
    // Single-beat build: the length field is accepted but has no effect.
    logic [LEN_BITS-1:0] unused_len;
    assign unused_len = bus.req_len;
    assign last_beat  = 1'b1;

    // Address register: start address on accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= bus.req_addr;
        end
    end
`endif

    // Direction and write data; PWDATA only changes when a write is accepted,
    // so reads leave the last write value on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= bus.req_write;
            if (bus.req_write) begin
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Capture PRDATA on the edge that ends a read ACCESS; held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if ((state_q == ACCESS) && !write_q) begin
            rdata_q <= bus.PRDATA;
        end
    end

    // State register; async reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the SETUP/ACCESS/RESP sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (!write_q)       state_d = RESP;
                else if (last_beat) state_d = IDLE;
                else                state_d = SETUP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = last_beat ? IDLE : SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and stream outputs decoded from state; req_ready also gated by reset.
    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PADDR     = addr_q;
    assign bus.PWRITE    = write_q;
    assign bus.PWDATA    = wdata_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_last  = (state_q == RESP) && last_beat;
    assign bus.rsp_data  = rdata_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: doc/apb2_master_bridge.md
Name: apb2_master_bridge

Overview:
- Command-to-APB2 master. Converts a simple valid/ready request stream into APB2 setup/access transfers.
- Drives the PADDR/PSEL/PENABLE/PWRITE/PWDATA bus that feeds memory_apb2_slave, and returns PRDATA on a valid/ready response stream.
- Sits between the host-facing command decoder and the APB2 register/memory slaves.
- Supports single transfers, plus auto-incrementing bursts (sequential read, write-fill).

Parameters:
- ADDR_BITS, 6, APB address width.
- DATA_BITS, 8, APB data width.
- LEN_BITS, 4, width of burst length field; burst beats = req_len + 1.

Ports:
- clk  input  1  system clock, rising edge; also PCLK of the bus.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  bridge can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_BITS  start address.
- req_wdata  input  DATA_BITS  write data, used for every beat of a write burst.
- req_len  input  LEN_BITS  beats minus one.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts read data.
- rsp_data  output  DATA_BITS  captured PRDATA.
- rsp_last  output  1  final beat of a read burst.
- busy  output  1  transfer in progress (state != IDLE).
- PADDR  output  ADDR_BITS  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_BITS  APB write data.
- PRDATA  input  DATA_BITS  APB read data.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; PSEL=PENABLE=PWRITE=0; PADDR=0; PWDATA=0; rsp_valid=rsp_last=0; rsp_data=0; busy=0; req_ready=0 while rst_n low, 1 on the first cycle after release.
- Reset mid-transfer aborts immediately. No bus cycle completes. Any pending response is dropped.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T: latch write/addr/wdata/len, beat counter=0, go to SETUP.
- SETUP (cycle T+1): PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA valid and held stable through ACCESS. Always goes to ACCESS.
- ACCESS (cycle T+2): PSEL=1, PENABLE=1. APB2 has no wait states, so access is exactly one cycle.
  - Read: PRDATA sampled on the edge ending ACCESS into rsp_data; go to RESP.
  - Write, beats remaining: go to SETUP of the next beat. PSEL stays 1, PENABLE drops to 0, PADDR increments.
  - Write, last beat: go to IDLE; PSEL=0.
- RESP:
  - rsp_valid=1; PSEL=PENABLE=0; rsp_data and rsp_last held stable until accepted.
  - On rsp_ready: go to SETUP for the next beat, or to IDLE if this was the last beat.
  - rsp_ready already high when rsp_valid rises: accepted in that same cycle (one RESP cycle).
- Latency:
  - Single write: request edge to IDLE = 3 cycles; back-to-back writes cost 2 cycles per beat.
  - Read: rsp_valid asserted 3 cycles after acceptance; 3 cycles per beat minimum.
- Address increment: PADDR = start + beat, modulo 2^ADDR_BITS, so 0x3F wraps to 0x00 with ADDR_BITS=6.
- req_len=0: exactly one transfer. req_len=2^LEN_BITS-1: 16 beats with defaults. Counter compare uses LEN_BITS width, no overflow.
- rsp_last=1 only on the response of the final beat.
- req_ready=0 in every state except IDLE. Requests presented while busy are held by the sender, not dropped.
- PWDATA is updated only on entry to SETUP of a write. It holds its value otherwise, including across reads.

Optional Feature:
- Macro: APB2_MASTER_BURST_EN.
- Defined: req_len honoured as above.
- Undefined:
  - req_len ignored; every request is a single beat.
  - rsp_last is tied to 1 whenever rsp_valid=1.
  - Beat counter and increment logic are not built.

Test Plan:
- Reset mid-ACCESS of a write to 0x05: pull rst_n low during PENABLE=1 -> PSEL/PENABLE go to 0 without waiting for clk; busy=0; after release a read of 0x05 returns the pre-reset contents.
- Single write 0xA5 to 0x03, then single read of 0x03 on memory_apb2_slave -> PSEL high for exactly 2 cycles per transfer, PENABLE only in the second; rsp_data=0xA5, rsp_last=1, rsp_valid asserted 3 cycles after acceptance.
- Write-fill burst: addr 0x00, len 7, data 0x3C -> 8 beats at 2 cycles/beat, PADDR 0x00..0x07; a subsequent read burst of the same range returns 0x3C on every beat, rsp_last only on beat 8.
- Read burst across RW/RO boundary: addr 0x06, len 3 -> PADDR 0x06..0x09, responses match the RW contents then mem_ro_values bytes 0 and 1.
- Backpressure: rsp_ready low for 5 cycles on beat 1 of a 2-beat read -> rsp_valid and rsp_data stable, PSEL=0 throughout, second SETUP starts the cycle after rsp_ready rises.
- Wrap: write-fill addr 0x3E, len 3, data 0x11 -> PADDR sequence 0x3E, 0x3F, 0x00, 0x01; req_ready=0 for the whole burst, 1 after the final ACCESS.
